pixel_scan_sched: RTL and testbench

- Time-multiplexes the single pixel output port ({color, y, x}, driven to the LED/matrix driver) between two snake segment sources and a win-banner overlay.
- Snapshots both snakes' segment coordinates at each frame start, so a game-logic move mid-frame never tears the display.
- Sequences per-pixel dwell and blanking intervals.
- Sits between the game-state FSM and the pixel driver, replacing ad-hoc change counters.

---
 rtl/pixel_scan_sched_pkg.sv | 44 ++++
 rtl/pixel_scan_sched_if.sv | 29 ++
 rtl/pixel_scan_sched_seg_snapshot.sv | 54 +++++
 rtl/pixel_scan_sched.sv | 114 +++++++++++
 tb/tb_pixel_scan_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_scan_sched_pkg.sv
// pixel_scan_sched_pkg: shared state encoding, colors, win codes and board limits
package pixel_scan_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SHOW,
        ST_BLNK,
        ST_WIN
    } state_t;

    typedef struct packed {
        logic [2:0] color;
        logic [3:0] y;
        logic [2:0] x;
    } pixel_t;

    localparam logic [2:0] C_HEAD = 3'b111;
    localparam logic [2:0] C_P0   = 3'b001;
    localparam logic [2:0] C_P1   = 3'b010;
    localparam logic [2:0] C_DRAW = 3'b100;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P0   = 2'b01;
    localparam logic [1:0] W_P1   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    localparam logic [2:0] X_MAX = 3'd7;
    localparam logic [3:0] Y_MAX = 4'd15;

    // Banner pixel for a given winner: P0 top-left, P1 bottom-right, draw near the centre
    function automatic pixel_t win_pixel(input logic [1:0] code);
        pixel_t p;
        p = '0;
        if (code == W_P1)
            p = '{color: C_P1, y: Y_MAX, x: X_MAX};
        else if (code == W_DRAW)
            p = '{color: C_DRAW, y: Y_MAX >> 1, x: X_MAX >> 1};
        else if (code == W_P0)
            p.color = C_P0;
        return p;
    endfunction

endpackage

// File: rtl/pixel_scan_sched_if.sv
// pixel_scan_sched_if: game-side inputs and pixel-driver outputs of the scan scheduler
interface pixel_scan_sched_if #(
    parameter int SEG_N = 5
);

    logic                 en;
    logic [1:0]           win_code;
    logic [3*SEG_N-1:0]   s0_x;
    logic [4*SEG_N-1:0]   s0_y;
    logic [3*SEG_N-1:0]   s1_x;
    logic [4*SEG_N-1:0]   s1_y;
    logic [2:0]           pix_x;
    logic [3:0]           pix_y;
    logic [2:0]           pix_color;
    logic                 pix_valid;
    logic                 frame_done;
    logic                 win_latched;

    modport master (
        output en, win_code, s0_x, s0_y, s1_x, s1_y,
        input  pix_x, pix_y, pix_color, pix_valid, frame_done, win_latched
    );

    modport slave (
        input  en, win_code, s0_x, s0_y, s1_x, s1_y,
        output pix_x, pix_y, pix_color, pix_valid, frame_done, win_latched
    );

endinterface

// File: rtl/pixel_scan_sched_seg_snapshot.sv
// pixel_scan_sched_seg_snapshot: frame-stable copy of both snakes with an indexed segment read
module pixel_scan_sched_seg_snapshot #(
    parameter int SEG_N = 5,
    localparam int IW = $clog2(2*SEG_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [IW-1:0]      idx,
    input  logic [3*SEG_N-1:0] s0_x,
    input  logic [4*SEG_N-1:0] s0_y,
    input  logic [3*SEG_N-1:0] s1_x,
    input  logic [4*SEG_N-1:0] s1_y,
    output logic [2:0]         x,
    output logic [3:0]         y,
    output logic               snake_sel
);

    logic [3*SEG_N-1:0] snap_s0_x, snap_s1_x, src_x;
    logic [4*SEG_N-1:0] snap_s0_y, snap_s1_y, src_y;
    int                 k;

    // Capture both coordinate buses once per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_s0_x <= '0;
            snap_s0_y <= '0;
            snap_s1_x <= '0;
            snap_s1_y <= '0;
        end else if (load) begin
            snap_s0_x <= s0_x;
            snap_s0_y <= s0_y;
            snap_s1_x <= s1_x;
            snap_s1_y <= s1_y;
        end
    end

    // Read segment idx; during load the live buses are read so the first pixel needs no extra cycle
    always_comb begin
        snake_sel = int'(idx) >= SEG_N;
        k = int'(idx) - (snake_sel ? SEG_N : 0);
        src_x = snake_sel ? (load ? s1_x : snap_s1_x) : (load ? s0_x : snap_s0_x);
        src_y = snake_sel ? (load ? s1_y : snap_s1_y) : (load ? s0_y : snap_s0_y);
        x = '0;
        y = '0;
        for (int i = 0; i < SEG_N; i++) begin
            if (k == i) begin
                x = src_x[3*i +: 3];
                y = src_y[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/pixel_scan_sched.sv
// pixel_scan_sched: time-multiplexes two snakes and a win banner onto one registered pixel port
module pixel_scan_sched #(
    parameter int SEG_N = 5,
    parameter int DWELL = 3000,
    parameter int BLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    pixel_scan_sched_if.slave bus
);

    import pixel_scan_sched_pkg::*;

    localparam int IW   = $clog2(2*SEG_N);
    localparam int CMAX = DWELL > BLANK ? DWELL : BLANK;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;

    state_t          state, nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            done_nxt, load;
    logic            dwell_end, blank_end, last_pix, head;
    logic [2:0]      seg_x;
    logic [3:0]      seg_y;
    logic            snake_sel;
    pixel_t          pix, show_pix;
    logic            pix_valid, frame_done, win_latched;

    assign dwell_end = cnt == CW'(DWELL - 1);
    assign blank_end = cnt == CW'(BLANK - 1);
    assign last_pix  = idx == IW'(2*SEG_N - 1);
    assign head      = idx_nxt == '0 || idx_nxt == IW'(SEG_N);

    pixel_scan_sched_seg_snapshot #(.SEG_N(SEG_N)) u_snap (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .idx       (idx_nxt),
        .s0_x      (bus.s0_x),
        .s0_y      (bus.s0_y),
        .s1_x      (bus.s1_x),
        .s1_y      (bus.s1_y),
        .x         (seg_x),
        .y         (seg_y),
        .snake_sel (snake_sel)
    );

    assign show_pix = '{color: head ? C_HEAD : snake_sel ? C_P1 : C_P0, y: seg_y, x: seg_x};

    // Next-state, counter and index sequencing for the scan
    always_comb begin
        nxt      = state;
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        load     = 1'b0;
        case (state)
            ST_IDLE: nxt = bus.en ? ST_SNAP : ST_IDLE;
            ST_SNAP: begin
                load    = 1'b1;
                idx_nxt = '0;
                cnt_nxt = '0;
                nxt     = bus.win_code != W_NONE ? ST_WIN : ST_SHOW;
            end
            ST_SHOW: begin
                cnt_nxt = dwell_end ? '0 : cnt + CW'(1);
                nxt     = dwell_end ? ST_BLNK : ST_SHOW;
            end
            ST_BLNK: begin
                cnt_nxt = blank_end ? '0 : cnt + CW'(1);
                if (blank_end && !last_pix) begin
                    idx_nxt = idx + IW'(1);
                    nxt     = ST_SHOW;
                end else if (blank_end) begin
                    done_nxt = 1'b1;
                    nxt      = bus.en ? ST_SNAP : ST_IDLE;
                end
            end
            ST_WIN:  nxt = ST_WIN;
            default: nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered pixel outputs; blanking and SNAP hold the last pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            pix         <= '0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            win_latched <= 1'b0;
        end else begin
            state       <= nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            frame_done  <= done_nxt;
            pix_valid   <= nxt == ST_SHOW || nxt == ST_WIN;
            win_latched <= win_latched || nxt == ST_WIN;
            pix         <= nxt == ST_SHOW ? show_pix :
                           nxt == ST_IDLE ? '0 :
                           (state == ST_SNAP && nxt == ST_WIN) ? win_pixel(bus.win_code) : pix;
        end
    end

    assign bus.pix_x       = pix.x;
    assign bus.pix_y       = pix.y;
    assign bus.pix_color   = pix.color;
    assign bus.pix_valid   = pix_valid;
    assign bus.frame_done  = frame_done;
    assign bus.win_latched = win_latched;

endmodule

// File: tb/tb_pixel_scan_sched.sv
// tb_pixel_scan_sched: directed scenario bench for the pixel scan scheduler
module tb_pixel_scan_sched;

    localparam int SEG_N = 5;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int PER   = DWELL + BLANK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_scan_sched_if #(.SEG_N(SEG_N)) bus ();

    pixel_scan_sched #(.SEG_N(SEG_N), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]  ex [10];
    logic [3:0]  ey [10];
    logic [2:0]  ec [10];
    logic [12:0] obs, want;

    assign obs = {bus.win_latched, bus.pix_valid, bus.frame_done, bus.pix_color, bus.pix_y, bus.pix_x};

    function automatic logic [12:0] px(logic lat, logic v, logic d, logic [2:0] c, logic [3:0] y, logic [2:0] x);
        return {lat, v, d, c, y, x};
    endfunction

    function automatic logic [12:0] frame_exp(int c);
        int k, ph;
        k  = (c - 1) / PER;
        ph = (c - 1) % PER;
        return px(1'b0, ph < DWELL, 1'b0, ec[k], ey[k], ex[k]);
    endfunction

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset got %h want %h", obs, 13'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL idle cyc %0d got %h want %h", c, obs, 13'd0);
            end
        end
    endtask

    task automatic test_frame;
        bus.en = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL snap got %h want %h", obs, 13'd0);
        end
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            want = c < 51 ? frame_exp(c) : px(1'b0, 1'b0, 1'b1, ec[9], ey[9], ex[9]);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL frame cyc %0d got %h want %h", c, obs, want);
            end
        end
    endtask

    task automatic test_mid_snapshot;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            want = c < 51 ? frame_exp(c) : px(1'b0, 1'b0, 1'b1, ec[9], ey[9], ex[9]);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL snapshot cyc %0d got %h want %h", c, obs, want);
            end
            if (c == 17) bus.s0_x = {5{3'd5}};
        end
        for (int k = 0; k < 5; k++) ex[k] = 3'd5;
    endtask

    task automatic test_en_drop;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            want = c < 51 ? frame_exp(c) : c == 51 ? px(1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 3'd0) : 13'd0;
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL en_drop cyc %0d got %h want %h", c, obs, want);
            end
            if (c == 32) bus.en = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        bus.en = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            want = frame_exp(c);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL pre_rst cyc %0d got %h want %h", c, obs, want);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL async_rst got %h want %h", obs, 13'd0);
        end
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL rst_held got %h want %h", obs, 13'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL rst_snap got %h want %h", obs, 13'd0);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            want = frame_exp(c);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL restart cyc %0d got %h want %h", c, obs, want);
            end
        end
        bus.en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_win_p1;
        bus.en = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            want = c < 51 ? frame_exp(c) :
                   c == 51 ? px(1'b0, 1'b0, 1'b1, ec[9], ey[9], ex[9]) :
                   px(1'b1, 1'b1, 1'b0, 3'b010, 4'd15, 3'd7);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL win_p1 cyc %0d got %h want %h", c, obs, want);
            end
            if (c == 10) bus.win_code = 2'b10;
            if (c == 52) begin
                bus.win_code = 2'b00;
                bus.en = 1'b0;
            end
        end
    endtask

    task automatic test_win_draw;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL win_clear got %h want %h", obs, 13'd0);
        end
        rst = 1'b0;
        bus.win_code = 2'b11;
        bus.en = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL draw_snap got %h want %h", obs, 13'd0);
        end
        bus.en = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            want = px(1'b1, 1'b1, 1'b0, 3'b100, 4'd7, 3'd3);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL draw cyc %0d got %h want %h", c, obs, want);
            end
            if (c == 5) bus.win_code = 2'b01;
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.win_code = 2'b00;
        bus.s0_x     = '0;
        bus.s0_y     = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        bus.s1_x     = {5{3'd7}};
        bus.s1_y     = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
        ex = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        ey = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        ec = '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001, 3'b111, 3'b010, 3'b010, 3'b010, 3'b010};
        test_reset();
        test_frame();
        test_mid_snapshot();
        test_en_drop();
        test_reset_mid();
        test_win_p1();
        test_win_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
